pipe_reg_chain: RTL and testbench

- Parametrised successor to the team's single-bit D flip-flop: a WIDTH-bit, DEPTH-stage register pipeline with valid/ready flow control.
- Adds a programmable reset value, a flush, and an occupancy count.
- Bubble-collapsing: empty stages absorb stalled data, so the chain fills completely under backpressure.
- Used as the generic retiming/elastic stage between datapath blocks.

---
 rtl/pipe_reg_chain.sv | 78 +++++++
 tb/tb_pipe_reg_chain.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: WIDTH-bit, DEPTH-stage bubble-collapsing register pipeline
// with valid/ready flow control, flush and occupancy count.
module pipe_reg_chain #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid_i,
    input  logic [WIDTH-1:0]           in_data_i,
    output logic                       in_ready_o,
    output logic                       out_valid_o,
    output logic [WIDTH-1:0]           out_data_o,
    input  logic                       out_ready_i,
    input  logic                       flush_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] v_q, v_d, adv;
    logic [WIDTH-1:0] d_q [DEPTH];
    logic [WIDTH-1:0] d_d [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    logic             tail, in_xfer, out_xfer;

    // A stage may advance unless it and every stage downstream of it are full and the output stalls.
    always_comb begin
        adv  = '0;
        tail = 1'b1;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            tail   = tail & v_q[k];
            adv[k] = !tail | out_ready_i;
        end
    end

    assign in_ready_o  = adv[0] & !flush_i;
    assign in_xfer     = in_valid_i & in_ready_o;
    assign out_xfer    = v_q[DEPTH-1] & out_ready_i;
    assign out_valid_o = v_q[DEPTH-1];
    assign out_data_o  = d_q[DEPTH-1];
    assign count_o     = count_q;

    always_comb begin
        v_d = v_q;
        d_d = d_q;
        count_d = flush_i ? '0 :
                  (in_xfer && !out_xfer) ? count_q + CW'(1) :
                  (out_xfer && !in_xfer) ? count_q - CW'(1) : count_q;
        if (flush_i) begin
            v_d = '0;
        end else begin
            if (adv[0]) begin
                v_d[0] = in_valid_i;
                if (in_valid_i) d_d[0] = in_data_i;
            end
            // Bubbles clear the valid bit but leave the data register untouched.
            for (int k = 1; k < DEPTH; k++) begin
                if (adv[k]) begin
                    v_d[k] = v_q[k-1];
                    if (v_q[k-1]) d_d[k] = d_q[k-1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            v_q     <= '0;
            count_q <= '0;
            for (int k = 0; k < DEPTH; k++) d_q[k] <= RST_VAL;
        end else begin
            v_q     <= v_d;
            d_q     <= d_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb_pipe_reg_chain: directed and random stimulus against a word-position
// model of the chain, checked every cycle.
module tb_pipe_reg_chain;
    localparam int D = 4;
    localparam int CW = $clog2(D + 1);

    logic clk = 0, reset = 0, in_valid_i = 0, out_ready_i = 0, flush_i = 0;
    logic [7:0] in_data_i = 0;
    logic in_ready_o, out_valid_o;
    logic [7:0] out_data_o;
    logic [CW-1:0] count_o;

    pipe_reg_chain #(.WIDTH(8), .DEPTH(D), .RST_VAL(8'h00)) dut (
        .clk(clk), .reset(reset), .in_valid_i(in_valid_i), .in_data_i(in_data_i),
        .in_ready_o(in_ready_o), .out_valid_o(out_valid_o), .out_data_o(out_data_o),
        .out_ready_i(out_ready_i), .flush_i(flush_i), .count_o(count_o)
    );

    always #5 clk = ~clk;

    // Model: words held oldest-first, each with its stage index.
    int         pos[$];
    logic [7:0] dat[$];
    logic [7:0] emitted[$];
    logic [7:0] last_out = 8'h00;
    bit         last_acc;
    int         vectors = 0, errs = 0;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        if (a !== e) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    function automatic bit m_out_valid();
        return pos.size() > 0 && pos[0] == D - 1;
    endfunction

    function automatic bit m_ready();
        return (pos.size() < D || out_ready_i) && !flush_i;
    endfunction

    task automatic step();
        int         npos[$];
        logic [7:0] ndat[$];
        bit         occ[D];
        bit         fire;
        #1;
        vectors++;
        chk("in_ready", in_ready_o, m_ready());
        chk("out_valid", out_valid_o, m_out_valid());
        chk("out_data", out_data_o, last_out);
        chk("count", count_o, pos.size());
        last_acc = reset && in_valid_i && m_ready();
        if (!reset) begin
            pos.delete(); dat.delete(); last_out = 8'h00;
        end else if (flush_i) begin
            if (m_out_valid() && out_ready_i) emitted.push_back(dat[0]);
            pos.delete(); dat.delete();
        end else begin
            foreach (occ[q]) occ[q] = 0;
            foreach (pos[i]) occ[pos[i]] = 1;
            fire = m_out_valid() && out_ready_i;
            foreach (pos[i]) begin
                int p;
                bit stall;
                p = pos[i];
                stall = !out_ready_i;
                if (i == 0 && fire) begin
                    emitted.push_back(dat[0]);
                end else begin
                    for (int q = p; q < D; q++) if (!occ[q]) stall = 0;
                    if (!stall) begin
                        p++;
                        if (p == D - 1) last_out = dat[i];
                    end
                    npos.push_back(p); ndat.push_back(dat[i]);
                end
            end
            if (last_acc) begin
                npos.push_back(0); ndat.push_back(in_data_i);
                if (D == 1) last_out = in_data_i;
            end
            pos = npos; dat = ndat;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int j;
        @(posedge clk); #1;
        // 1. reset with in_valid asserted
        reset = 0; in_valid_i = 1; in_data_i = 8'h55;
        step(); step();
        chk("rst_valid", out_valid_o, 1'b0);
        chk("rst_data", out_data_o, 8'h00);
        chk("rst_count", count_o, 0);
        reset = 1; in_valid_i = 0; #1;
        chk("rst_ready", in_ready_o, 1'b1);

        // 2. streaming
        out_ready_i = 1; emitted.delete();
        for (int i = 1; i <= 8; i++) begin
            in_valid_i = 1; in_data_i = 8'(i);
            step();
            if (i == 4) begin
                chk("lat_valid", out_valid_o, 1'b1);
                chk("lat_data", out_data_o, 8'h01);
            end
            if (i == 6) chk("stream_count", count_o, 4);
        end
        in_valid_i = 0;
        for (int t = 0; t < 20 && pos.size() > 0; t++) step();
        chk("stream_n", emitted.size(), 8);
        foreach (emitted[i]) chk("stream_word", emitted[i], i + 1);

        // 3. backpressure
        out_ready_i = 0; emitted.delete(); j = 0;
        for (int t = 0; t < 8; t++) begin
            in_valid_i = 1; in_data_i = 8'h11 + 8'(j);
            step();
            if (last_acc) j++;
        end
        chk("bp_accepted", j, 4);
        #1;
        chk("bp_ready", in_ready_o, 1'b0);
        chk("bp_count", count_o, 4);
        out_ready_i = 1;
        for (int t = 0; t < 20 && j < 6; t++) begin
            in_data_i = 8'h11 + 8'(j);
            step();
            if (last_acc) j++;
        end
        in_valid_i = 0;
        for (int t = 0; t < 20 && pos.size() > 0; t++) step();
        chk("bp_n", emitted.size(), 6);
        foreach (emitted[i]) chk("bp_word", emitted[i], 8'h11 + i);
        chk("bp_drained", count_o, 0);

        // 4. bubble collapse
        out_ready_i = 0; emitted.delete();
        for (int t = 0; t < 8; t++) begin
            in_valid_i = (t == 0 || t == 3);
            in_data_i = (t == 0) ? 8'hA0 : 8'hB0;
            step();
        end
        chk("bub_count", count_o, 2);
        chk("bub_data", out_data_o, 8'hA0);
        out_ready_i = 1;
        step();
        chk("bub_first", emitted.size() > 0 ? emitted[0] : 8'hxx, 8'hA0);
        step();
        chk("bub_second", emitted.size() > 1 ? emitted[1] : 8'hxx, 8'hB0);

        // 5. flush
        out_ready_i = 0; emitted.delete();
        for (int t = 0; t < 6; t++) begin
            in_valid_i = (t < 3); in_data_i = 8'hC1 + 8'(t);
            step();
        end
        flush_i = 1; in_valid_i = 1; in_data_i = 8'hFF; #1;
        chk("fl_ready", in_ready_o, 1'b0);
        step();
        flush_i = 0; in_valid_i = 0; #1;
        chk("fl_count", count_o, 0);
        chk("fl_valid", out_valid_o, 1'b0);
        out_ready_i = 1;
        for (int t = 0; t < 8; t++) step();
        chk("fl_none", emitted.size(), 0);

        // 6. reset mid-operation
        out_ready_i = 0;
        for (int t = 0; t < 6; t++) begin
            in_valid_i = 1; in_data_i = 8'hD0 + 8'(t);
            step();
        end
        chk("mid_full", count_o, 4);
        in_valid_i = 0; out_ready_i = 1; reset = 0; emitted.delete();
        step();
        reset = 1; #1;
        chk("mid_count", count_o, 0);
        chk("mid_valid", out_valid_o, 1'b0);
        chk("mid_data", out_data_o, 8'h00);
        for (int t = 0; t < 8; t++) step();
        chk("mid_none", emitted.size(), 0);

        // random traffic
        for (int t = 0; t < 400; t++) begin
            in_valid_i  = $urandom_range(0, 3) != 0;
            in_data_i   = 8'($urandom);
            out_ready_i = $urandom_range(0, 2) != 0;
            flush_i     = $urandom_range(0, 24) == 0;
            reset       = $urandom_range(0, 49) != 0;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
